speed_meas_ctrl: RTL and testbench
==================================

Name: speed_meas_ctrl

Overview:
Sequencing controller for the two-sensor speed measurement path on the 12 MHz board clock.
- Synchronises both gate sensors and detects the start and stop edges.
- Times the interval in clock ticks and handles timeout and abort.
- Hands the tick count to the downstream speed divider / 7-segment stage over a valid/ready handshake.
- Freezes further measurements for a display-hold window so the shown speed stays readable.

Parameters:
- CNT_W, 32, width of tick counter and res_ticks.
- TIMEOUT_CYCLES, 24_000_000, max start-to-stop interval in cycles (2 s at 12 MHz).
- HOLD_CYCLES, 36_000_000, post-report dead time in cycles (3 s).

Ports:
- clk  in  1  system clock, 12 MHz.
- rst  in  1  reset; synchronous, active-low.
- enable  in  1  measurement enable.
- sensor_a  in  1  async gate sensor A, active-high.
- sensor_b  in  1  async gate sensor B, active-high.
- res_ready  in  1  downstream accepts result.
- res_valid  out  1  result available.
- res_ticks  out  CNT_W  cycles between start and stop edges.
- res_dir  out  1  0 = A→B, 1 = B→A.
- busy  out  1  state != IDLE.
- timeout_err  out  1  one-cycle pulse on timeout.
- hold_active  out  1  high in HOLD.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state IDLE; all outputs 0; counters 0.
  - Synchroniser and edge-history flops are set to 1, so a sensor held high across reset release produces no edge.
- Each sensor passes through a 2-FF synchroniser and then a rising-edge detector.
  - Internal edge pulse appears 3 cycles after the pin rises.
  - Both paths have identical latency, so the tick count is unaffected.
- States: IDLE, TIMING, REPORT, HOLD.
- IDLE:
  - enable=1 and an edge on exactly one sensor → TIMING. Latch dir (A edge → 0, B edge → 1), cnt := 1.
  - Edges on both sensors in the same cycle → ignored, stay IDLE.
  - enable=0 → stay IDLE.
- TIMING:
  - Each cycle without a stop edge, cnt := cnt + 1.
  - Stop edge is an edge on the opposite sensor. On it: res_ticks := cnt (= t_stop − t_start), → REPORT.
  - Repeat edges on the starting sensor are ignored.
  - cnt reaching TIMEOUT_CYCLES with no stop edge → timeout_err=1 for that cycle, → IDLE.
  - Stop edge and timeout in the same cycle → stop edge wins.
  - cnt never exceeds TIMEOUT_CYCLES, so CNT_W must hold TIMEOUT_CYCLES.
  - enable=0 → abort to IDLE, no error pulse, no result.
- REPORT:
  - res_valid=1; res_ticks and res_dir stable until res_valid && res_ready at a clk edge, then → HOLD.
  - res_valid rises the cycle after the stop edge, so the minimum REPORT residency is 1 cycle.
  - enable is ignored and sensor edges are ignored.
- HOLD:
  - hold_active=1; hold counter runs from 0 to HOLD_CYCLES−1, then → IDLE.
  - Sensor edges and enable are ignored.
  - res_ticks and res_dir keep their last value; only res_valid drops.
- Reset mid-operation:
  - Returns to IDLE on the next edge; any pending result is discarded.
  - res_valid=0 the cycle after rst sampled low.
- Boundary widths: res_ticks is never 0, because the stop edge needs at least 1 cycle after the start edge.

Optional Feature:
- Macro: SPEED_CTRL_BIDIR_EN.
- Defined: either sensor may start a measurement, and res_dir reports the direction.
- Undefined:
  - Only sensor_a starts; a B edge in IDLE is ignored.
  - Only a B edge stops.
  - res_dir is tied to 0.

Decomposition:
- Package speed_pkg holds:
  - CLK_HZ = 12_000_000.
  - typedef enum logic [1:0] ctrl_state_t {IDLE, TIMING, REPORT, HOLD}.
  - typedef enum logic {DIR_AB, DIR_BA} dir_t.
  - Default TIMEOUT/HOLD constants.
- Sub-module sensor_edge_sync: 2-FF synchroniser plus rising-edge pulse, reset-to-1 flops. Instantiated once per sensor.

Test Plan:
- Default params, res_ready=1: A pulse, B pulse 112_500 cycles later → res_ticks=112_500, res_dir=0, res_valid high exactly 1 cycle, hold_active for 36_000_000 cycles.
- TIMEOUT_CYCLES=1000, HOLD_CYCLES=200: A pulse only → timeout_err single pulse 1000 cycles after the start edge; no res_valid; busy=0 afterwards.
- res_ready=0 for 50 cycles after stop; extra A/B pulses during REPORT → res_valid held 50+ cycles, res_ticks unchanged; accepted on the first ready cycle; HOLD entered.
- A and B rise in the same cycle → busy stays 0. Then A, A again 100 cycles later, B 500 cycles after the first A → res_ticks=500.
- rst low 1 cycle during TIMING, sensors held high across release → busy=0, res_valid=0 next cycle; no spurious start.
- With SPEED_CTRL_BIDIR_EN: B then A after 300 cycles → res_ticks=300, res_dir=1. Without the macro: same stimulus → busy stays 0.

Source files
------------

// File: rtl/speed_meas_ctrl_pkg.sv
// Shared types and default timing constants for the two-gate speed measurement controller.
package speed_pkg;

    localparam int unsigned CLK_HZ             = 12_000_000;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 24_000_000;  // 2 s at CLK_HZ
    localparam int unsigned HOLD_CYCLES_DEF    = 36_000_000;  // 3 s at CLK_HZ

    typedef enum logic [1:0] {
        IDLE,
        TIMING,
        REPORT,
        HOLD
    } ctrl_state_t;

    typedef enum logic {
        DIR_AB,
        DIR_BA
    } dir_t;

endpackage

// File: rtl/speed_meas_ctrl_sensor_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge pulse for one asynchronous gate sensor.
// Flops reset to 1 so a sensor already high at reset release never reports an edge.
module sensor_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sensor_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;
    logic rise_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sensor_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            rise_q  <= sync2_q & ~hist_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/speed_meas_ctrl.sv
// Gate-to-gate interval timer with timeout, valid/ready result hand-off and display hold.
// SPEED_CTRL_BIDIR_EN: when defined, either sensor may start a run and res_dir_o reports direction.
//
// state  | meaning
// IDLE   | waiting for a start edge while enabled
// TIMING | counting ticks until the opposite sensor fires, timeout or abort
// REPORT | result presented, waiting for res_ready_i
// HOLD   | dead time so the displayed speed stays readable
module speed_meas_ctrl
    import speed_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             sensor_a_i,
    input  logic             sensor_b_i,
    input  logic             res_ready_i,
    output logic             res_valid_o,
    output logic [CNT_W-1:0] res_ticks_o,
    output logic             res_dir_o,
    output logic             busy_o,
    output logic             timeout_err_o,
    output logic             hold_active_o
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);

    logic edge_a;
    logic edge_b;
    logic start_a;
    logic start_b;
    logic stop_edge;

    ctrl_state_t       state_q;
    dir_t              dir_q;
    dir_t              res_dir_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  ticks_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              timeout_q;

    sensor_edge_sync u_sync_a (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sensor_i (sensor_a_i),
        .rise_o   (edge_a)
    );

    sensor_edge_sync u_sync_b (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sensor_i (sensor_b_i),
        .rise_o   (edge_b)
    );

    // Simultaneous edges on both gates carry no direction, so they never start a run.
`ifdef SPEED_CTRL_BIDIR_EN
    assign start_a   = edge_a & ~edge_b;
    assign start_b   = edge_b & ~edge_a;
    assign stop_edge = (dir_q == DIR_BA) ? edge_a : edge_b;
`else
    assign start_a   = edge_a & ~edge_b;
    assign start_b   = 1'b0;
    assign stop_edge = edge_b;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            dir_q      <= DIR_AB;
            res_dir_q  <= DIR_AB;
            cnt_q      <= '0;
            ticks_q    <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable_i && (start_a || start_b)) begin
                        state_q <= TIMING;
                        dir_q   <= start_b ? DIR_BA : DIR_AB;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                TIMING: begin
                    // Stop is checked before timeout so an edge on the last legal cycle still reports.
                    if (!enable_i) begin
                        state_q <= IDLE;
                    end else if (stop_edge) begin
                        ticks_q   <= cnt_q;
                        res_dir_q <= dir_q;
                        state_q   <= REPORT;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                REPORT: begin
                    if (res_ready_i) begin
                        state_q    <= HOLD;
                        hold_cnt_q <= '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_valid_o   = (state_q == REPORT);
    assign busy_o        = (state_q != IDLE);
    assign hold_active_o = (state_q == HOLD);
    assign res_ticks_o   = ticks_q;
    assign res_dir_o     = res_dir_q;
    assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_speed_meas_ctrl.sv
// Scoreboard bench for speed_meas_ctrl with shortened timeout and hold windows.
module tb_speed_meas_ctrl;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned TO    = 1000;
    localparam int unsigned HOLD  = 200;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             enable_i;
    logic             sensor_a_i;
    logic             sensor_b_i;
    logic             res_ready_i;
    logic             res_valid_o;
    logic [CNT_W-1:0] res_ticks_o;
    logic             res_dir_o;
    logic             busy_o;
    logic             timeout_err_o;
    logic             hold_active_o;

    typedef struct {
        logic [31:0] ticks;
        logic        dir;
    } exp_t;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   n_timeouts = 0;

    always #5 clk_i = ~clk_i;

    speed_meas_ctrl #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TO),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .sensor_a_i    (sensor_a_i),
        .sensor_b_i    (sensor_b_i),
        .res_ready_i   (res_ready_i),
        .res_valid_o   (res_valid_o),
        .res_ticks_o   (res_ticks_o),
        .res_dir_o     (res_dir_o),
        .busy_o        (busy_o),
        .timeout_err_o (timeout_err_o),
        .hold_active_o (hold_active_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // First sensor rises, second sensor rises n cycles later; each held 3 cycles (n >= 4).
    task automatic pair(input logic first_b, input int n);
        if (first_b) sensor_b_i = 1'b1; else sensor_a_i = 1'b1;
        step(3);
        sensor_a_i = 1'b0;
        sensor_b_i = 1'b0;
        step(n - 3);
        if (first_b) sensor_a_i = 1'b1; else sensor_b_i = 1'b1;
        step(3);
        sensor_a_i = 1'b0;
        sensor_b_i = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (!res_valid_o && i < 40) begin
            step(1);
            i++;
        end
        check_eq(tag, res_valid_o, 1);
    endtask

    task automatic wait_busy(input string tag);
        int i = 0;
        while (!busy_o && i < 40) begin
            step(1);
            i++;
        end
        check_eq(tag, busy_o, 1);
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (busy_o && i < 400) begin
            step(1);
            i++;
        end
        check_eq(tag, busy_o, 0);
    endtask

    // Accepted results are popped from the scoreboard at the handshake.
    always @(negedge clk_i) begin : mon
        exp_t e;
        if (timeout_err_o) n_timeouts++;
        if (res_valid_o && res_ready_i) begin
            check_eq("result_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("res_ticks", res_ticks_o, e.ticks);
                check_eq("res_dir", res_dir_o, e.dir);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hc;
        int bs;
        int k;
        rst_i       = 1'b0;
        enable_i    = 1'b0;
        sensor_a_i  = 1'b0;
        sensor_b_i  = 1'b0;
        res_ready_i = 1'b1;
        step(3);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_valid", res_valid_o, 0);
        check_eq("rst_hold", hold_active_o, 0);
        check_eq("rst_timeout", timeout_err_o, 0);
        check_eq("rst_ticks", res_ticks_o, 0);
        check_eq("rst_dir", res_dir_o, 0);
        rst_i = 1'b1;
        step(5);
        enable_i = 1'b1;

        // Basic A->B measurement with immediate acceptance and full hold window
        sb.push_back('{ticks: 32'd112, dir: 1'b0});
        pair(1'b0, 112);
        wait_valid("t1_valid");
        step(1);
        check_eq("t1_valid_one_cycle", res_valid_o, 0);
        check_eq("t1_hold_on", hold_active_o, 1);
        hc = 0;
        while (hold_active_o && hc < 1000) begin
            hc++;
            step(1);
        end
        check_eq("t1_hold_len", hc, HOLD);
        check_eq("t1_idle", busy_o, 0);

        // Timeout: start edge only
        sensor_a_i = 1'b1;
        step(3);
        sensor_a_i = 1'b0;
        wait_busy("t2_start");
        k = 0;
        while (!timeout_err_o && k < 2000) begin
            step(1);
            k++;
        end
        check_eq("t2_timeout_delay", k, TO);
        check_eq("t2_idle_at_timeout", busy_o, 0);
        check_eq("t2_no_valid", res_valid_o, 0);
        step(1);
        check_eq("t2_pulse_one_cycle", timeout_err_o, 0);

        // Back-pressure with extra sensor edges during REPORT
        res_ready_i = 1'b0;
        sb.push_back('{ticks: 32'd250, dir: 1'b0});
        pair(1'b0, 250);
        wait_valid("t3_valid");
        for (int i = 0; i < 50; i++) begin
            if (i == 5)  sensor_a_i = 1'b1;
            if (i == 8)  sensor_a_i = 1'b0;
            if (i == 15) sensor_b_i = 1'b1;
            if (i == 18) sensor_b_i = 1'b0;
            step(1);
        end
        check_eq("t3_valid_held", res_valid_o, 1);
        check_eq("t3_ticks_held", res_ticks_o, 250);
        res_ready_i = 1'b1;
        step(1);
        check_eq("t3_valid_drop", res_valid_o, 0);
        check_eq("t3_hold", hold_active_o, 1);
        wait_idle("t3_idle");

        // Simultaneous edges ignored, then repeated start-sensor edge ignored
        sensor_a_i = 1'b1;
        sensor_b_i = 1'b1;
        step(3);
        sensor_a_i = 1'b0;
        sensor_b_i = 1'b0;
        bs = 0;
        for (int i = 0; i < 15; i++) begin
            if (busy_o) bs++;
            step(1);
        end
        check_eq("t4_simul_busy", bs, 0);
        sb.push_back('{ticks: 32'd500, dir: 1'b0});
        sensor_a_i = 1'b1;
        step(3);
        sensor_a_i = 1'b0;
        step(97);
        sensor_a_i = 1'b1;
        step(3);
        sensor_a_i = 1'b0;
        step(397);
        sensor_b_i = 1'b1;
        step(3);
        sensor_b_i = 1'b0;
        wait_valid("t4_valid");
        step(1);
        wait_idle("t4_idle");

        // Stop edge on the timeout cycle wins; shortest practical interval
        sb.push_back('{ticks: TO, dir: 1'b0});
        pair(1'b0, TO);
        wait_valid("t5_valid_tie");
        step(1);
        wait_idle("t5_idle_tie");
        sb.push_back('{ticks: 32'd4, dir: 1'b0});
        pair(1'b0, 4);
        wait_valid("t5_valid_short");
        step(1);
        wait_idle("t5_idle_short");

        // Reset pulse during TIMING with both sensors held high
        sensor_a_i = 1'b1;
        wait_busy("t6_start");
        sensor_b_i = 1'b1;
        rst_i = 1'b0;
        step(1);
        rst_i = 1'b1;
        check_eq("t6_busy_after_rst", busy_o, 0);
        check_eq("t6_valid_after_rst", res_valid_o, 0);
        bs = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy_o || res_valid_o) bs++;
            step(1);
        end
        sensor_a_i = 1'b0;
        sensor_b_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (busy_o) bs++;
            step(1);
        end
        check_eq("t6_no_spurious_start", bs, 0);

        // B first, A 300 cycles later
`ifdef SPEED_CTRL_BIDIR_EN
        sb.push_back('{ticks: 32'd300, dir: 1'b1});
        pair(1'b1, 300);
        wait_valid("t7_valid");
        step(1);
        wait_idle("t7_idle");
`else
        sensor_b_i = 1'b1;
        step(3);
        sensor_b_i = 1'b0;
        bs = 0;
        for (int i = 0; i < 297; i++) begin
            if (busy_o) bs++;
            step(1);
        end
        check_eq("t7_b_no_start", bs, 0);
        sensor_a_i = 1'b1;
        step(3);
        sensor_a_i = 1'b0;
        wait_busy("t7_a_start");
        enable_i = 1'b0;
        step(1);
        check_eq("t7_abort_idle", busy_o, 0);
        step(5);
        check_eq("t7_abort_no_valid", res_valid_o, 0);
        enable_i = 1'b1;
`endif

        step(5);
        check_eq("sb_drained", sb.size(), 0);
        check_eq("timeout_pulses", n_timeouts, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
